mem_port_arbiter: RTL and testbench

Shares one downstream memory port between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the core's `inst_*`/`data_*` interfaces and the single cache/memory interface. Each transaction is latched at grant and held stable until the memory responds. The response is routed only to the granted requester.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter_priority.sv | 37 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side inst/data ports plus the shared downstream memory port.
// slave = arbiter side, master = core and memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_read;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_resp;
    logic [DATA_W-1:0] inst_rdata;

    logic                data_read;
    logic                data_write;
    logic [DATA_W/8-1:0] data_mbe;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_resp;
    logic [DATA_W-1:0]   data_rdata;

    logic                mem_read;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_mbe;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_resp;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  inst_read, inst_addr,
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        input  mem_resp, mem_rdata,
        output inst_resp, inst_rdata, data_resp, data_rdata,
        output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
    );

    modport master (
        output inst_read, inst_addr,
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        output mem_resp, mem_rdata,
        input  inst_resp, inst_rdata, data_resp, data_rdata,
        input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// Combinational winner select. ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise the data port wins every conflict.
module arb_priority
    import arbiter_types::*;
(
    input  logic       i_inst_req,
    input  logic       i_data_req,
    input  arb_grant_t i_last_grant,
    output arb_grant_t o_grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        o_grant = GRANT_INST;
        if (i_inst_req && i_data_req) begin
            o_grant = (i_last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
        end else if (i_data_req) begin
            o_grant = GRANT_DATA;
        end
    end
`else
    // Fixed priority has no use for the grant history.
    logic w_unused;
    assign w_unused = i_last_grant;

    always_comb begin
        o_grant = GRANT_INST;
        if (i_data_req) begin
            o_grant = GRANT_DATA;
        end
        if (!i_inst_req && !i_data_req) begin
            o_grant = GRANT_INST;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// ARB_ROUND_ROBIN_EN adds a last_grant register for alternating conflicts.
module mem_port_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_mbe;
    logic                r_is_write;
    logic                w_load;
    logic                w_data_req;
    arb_grant_t          w_grant;
    arb_grant_t          w_last_grant;

    assign w_data_req = bus.data_read | bus.data_write;

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t r_last_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= GRANT_INST;
        end else if (w_load) begin
            r_last_grant <= w_grant;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = GRANT_INST;
`endif

    arb_priority u_arb_priority (
        .i_inst_req   (bus.inst_read),
        .i_data_req   (w_data_req),
        .i_last_grant (w_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mbe      <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                if (w_grant == GRANT_DATA) begin
                    r_addr     <= bus.data_addr;
                    r_wdata    <= bus.data_wdata;
                    r_mbe      <= bus.data_mbe;
                    r_is_write <= bus.data_write;   // read+write together resolves to write
                end else begin
                    r_addr     <= bus.inst_addr;
                    r_wdata    <= '0;
                    r_mbe      <= '0;
                    r_is_write <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.inst_read || w_data_req) begin
                    w_load       = 1'b1;
                    w_next_state = (w_grant == GRANT_DATA) ? DATA_BUSY : INST_BUSY;
                end
            end
            INST_BUSY, DATA_BUSY: begin
                if (bus.mem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.mem_read  = (r_state == INST_BUSY) || ((r_state == DATA_BUSY) && !r_is_write);
    assign bus.mem_write = (r_state == DATA_BUSY) && r_is_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_mbe   = r_mbe;

    assign bus.inst_resp  = (r_state == INST_BUSY) && bus.mem_resp;
    assign bus.data_resp  = (r_state == DATA_BUSY) && bus.mem_resp;
    assign bus.inst_rdata = (r_state == INST_BUSY) ? bus.mem_rdata : '0;
    assign bus.data_rdata = (r_state == DATA_BUSY) ? bus.mem_rdata : '0;

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(bus.data_read && bus.data_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; follows ARB_ROUND_ROBIN_EN if defined.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp_on(input logic [31:0] d);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = d;
        #1;
    endtask

    task automatic resp_off();
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"},   32'(bus.mem_read),  32'h0);
        chk({tag, "_mem_write"},  32'(bus.mem_write), 32'h0);
        chk({tag, "_mem_addr"},   bus.mem_addr,       32'h0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata,      32'h0);
        chk({tag, "_mem_mbe"},    32'(bus.mem_mbe),   32'h0);
        chk({tag, "_inst_resp"},  32'(bus.inst_resp), 32'h0);
        chk({tag, "_data_resp"},  32'(bus.data_resp), 32'h0);
        chk({tag, "_inst_rdata"}, bus.inst_rdata,     32'h0);
        chk({tag, "_data_rdata"}, bus.data_rdata,     32'h0);
    endtask

    initial begin
        logic exp_data;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.inst_read  = 1'b0;  bus.inst_addr  = 32'h0;
        bus.data_read  = 1'b0;  bus.data_write = 1'b0;
        bus.data_mbe   = 4'h0;  bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.mem_resp   = 1'b1;  bus.mem_rdata  = 32'hFFFF_FFFF;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'h0;
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Instruction read alone, memory answers 3 cycles after grant
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h60;
        tick();
        chk("i1_mem_read",  32'(bus.mem_read),  32'h1);
        chk("i1_mem_write", 32'(bus.mem_write), 32'h0);
        chk("i1_mem_addr",  bus.mem_addr,       32'h60);
        chk("i1_mem_mbe",   32'(bus.mem_mbe),   32'h0);
        chk("i1_inst_resp", 32'(bus.inst_resp), 32'h0);
        tick();
        tick();
        chk("i1_addr_hold", bus.mem_addr, 32'h60);
        resp_on(32'h0000_0013);
        chk("i1_inst_resp_pulse", 32'(bus.inst_resp), 32'h1);
        chk("i1_inst_rdata",      bus.inst_rdata,     32'h0000_0013);
        chk("i1_data_resp",       32'(bus.data_resp), 32'h0);
        bus.inst_read = 1'b0;
        resp_off();
        chk("i1_idle_resp",     32'(bus.inst_resp), 32'h0);
        chk("i1_idle_mem_read", 32'(bus.mem_read),  32'h0);

        // Data write alone
        bus.data_write = 1'b1;
        bus.data_addr  = 32'h100;
        bus.data_wdata = 32'hDEAD_BEEF;
        bus.data_mbe   = 4'h3;
        tick();
        chk("w_mem_write", 32'(bus.mem_write), 32'h1);
        chk("w_mem_read",  32'(bus.mem_read),  32'h0);
        chk("w_mem_addr",  bus.mem_addr,       32'h100);
        chk("w_mem_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
        chk("w_mem_mbe",   32'(bus.mem_mbe),   32'h3);
        tick();
        chk("w_hold_addr",  bus.mem_addr,       32'h100);
        chk("w_hold_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
        chk("w_hold_write", 32'(bus.mem_write), 32'h1);
        resp_on(32'h0);
        chk("w_data_resp", 32'(bus.data_resp), 32'h1);
        chk("w_inst_resp", 32'(bus.inst_resp), 32'h0);
        bus.data_write = 1'b0;
        resp_off();
        chk("w_idle_resp",  32'(bus.data_resp), 32'h0);
        chk("w_idle_write", 32'(bus.mem_write), 32'h0);

        // Reset in the middle of a data read, stray mem_resp afterwards
        bus.data_read  = 1'b1;
        bus.data_addr  = 32'h300;
        bus.data_wdata = 32'h0;
        bus.data_mbe   = 4'h0;
        tick();
        chk("r_busy_read", 32'(bus.mem_read), 32'h1);
        chk("r_busy_addr", bus.mem_addr,      32'h300);
        rst_n = 1'b0;
        bus.data_read = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        tick();
        resp_on(32'h5555_AAAA);
        chk("r_stray_data_resp",  32'(bus.data_resp), 32'h0);
        chk("r_stray_inst_resp",  32'(bus.inst_resp), 32'h0);
        chk("r_stray_data_rdata", bus.data_rdata,     32'h0);
        resp_off();
        chk("r_idle_read", 32'(bus.mem_read), 32'h0);

        // Four back-to-back conflicts, then the leftover instruction request
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h0;
        bus.data_read = 1'b1;
        bus.data_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            exp_data = RR ? (i % 2 == 0) : 1'b1;
            tick();
            chk($sformatf("c%0d_mem_addr", i), bus.mem_addr, exp_data ? 32'h200 : 32'h0);
            chk($sformatf("c%0d_mem_read", i), 32'(bus.mem_read), 32'h1);
            resp_on(32'h1000 + 32'(i));
            chk($sformatf("c%0d_data_resp", i), 32'(bus.data_resp), 32'(exp_data));
            chk($sformatf("c%0d_inst_resp", i), 32'(bus.inst_resp), 32'(!exp_data));
            if (i == 3) bus.data_read = 1'b0;
            resp_off();
        end
        tick();
        chk("c_last_addr", bus.mem_addr, 32'h0);
        resp_on(32'h0000_0777);
        chk("c_last_inst_resp",  32'(bus.inst_resp), 32'h1);
        chk("c_last_inst_rdata", bus.inst_rdata,     32'h0000_0777);
        bus.inst_read = 1'b0;
        resp_off();

        // Instruction requester drops its request right after grant
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h480;
        tick();
        bus.inst_read = 1'b0;
        bus.inst_addr = 32'h999;
        tick();
        chk("d_mem_addr", bus.mem_addr,      32'h480);
        chk("d_mem_read", 32'(bus.mem_read), 32'h1);
        resp_on(32'h0000_0ABC);
        chk("d_inst_resp",  32'(bus.inst_resp), 32'h1);
        chk("d_inst_rdata", bus.inst_rdata,     32'h0000_0ABC);
        resp_off();
        chk("d_idle_resp", 32'(bus.inst_resp), 32'h0);
        chk("d_no_regrant", 32'(bus.mem_read), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
